// File: rtl/ifu_pkg.sv
// ifu_pkg: shared RISC-V fetch constants and the buffered fetch entry type
package ifu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] inst;
  } fetch_t;
endpackage

// File: rtl/ifu_if.sv
// ifu_if: instruction-memory port, execute redirect and fetch/decode handshake
interface ifu_if;
  import ifu_pkg::*;
  logic            req_valid_o;
  logic [XLEN-1:0] req_addr_o;
  logic            req_ready_i;
  logic            rsp_valid_i;
  logic [XLEN-1:0] rsp_data_i;
  logic            jump_en_i;
  logic [XLEN-1:0] jump_addr_i;
  logic            inst_valid_o;
  logic            inst_ready_i;
  logic [XLEN-1:0] inst_o;
  logic [XLEN-1:0] inst_addr_o;
  modport master (
    output req_valid_o, req_addr_o, inst_valid_o, inst_o, inst_addr_o,
    input  req_ready_i, rsp_valid_i, rsp_data_i, jump_en_i, jump_addr_i, inst_ready_i
  );
  modport slave (
    input  req_valid_o, req_addr_o, inst_valid_o, inst_o, inst_addr_o,
    output req_ready_i, rsp_valid_i, rsp_data_i, jump_en_i, jump_addr_i, inst_ready_i
  );
endinterface

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous FIFO with flush; flush wins over push and pop
module ifu_fifo #(
  parameter int W = 32,
  parameter int D = 2,
  localparam int CW = $clog2(D + 1),
  localparam int AW = D > 1 ? $clog2(D) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0] mem_q [D];
  logic [AW-1:0] rd_q, wr_q, rd_d, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  // pointer/count next state; a push into a full FIFO is allowed only alongside a pop
  always_comb begin
    do_pop = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    rd_d = do_pop ? (rd_q == AW'(D - 1) ? '0 : rd_q + 1'b1) : rd_q;
    wr_d = do_push ? (wr_q == AW'(D - 1) ? '0 : wr_q + 1'b1) : wr_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  // storage needs no reset; stale slots are never read while empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
  // the producer's credit scheme must never push into a full FIFO
  always_ff @(posedge clk) begin
    if (!rst && !flush_i) assert (!(push_i && full_o && !pop_i));
  end
  assign dout_o = mem_q[rd_q];
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == CW'(D);
  assign count_o = cnt_q;
endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit issuing in-order word reads and buffering results for decode
module ifu
  import ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int MAX_OUTSTANDING = 2,
  parameter int BUF_DEPTH = 2,
  localparam int OW = $clog2(MAX_OUTSTANDING + 1),
  localparam int BW = $clog2(BUF_DEPTH + 1)
) (
  input logic   clk,
  input logic   rst,
  ifu_if.master bus
);
  logic [XLEN-1:0] pc_q, pc_d;
  logic [OW-1:0] out_q, out_d, kill_q, kill_d, aq_cnt;
  logic [BW-1:0] buf_cnt;
  logic [XLEN-1:0] aq_addr;
  logic aq_empty, aq_full, buf_empty, buf_full, accept, buf_push;
  fetch_t head;
  // issue credit, redirect and kill bookkeeping
  always_comb begin
    bus.req_valid_o = !rst && !bus.jump_en_i && int'(out_q) < MAX_OUTSTANDING
                      && int'(out_q) - int'(kill_q) + int'(buf_cnt) < BUF_DEPTH;
    bus.req_addr_o = pc_q;
    accept = bus.req_valid_o & bus.req_ready_i;
    buf_push = bus.rsp_valid_i & (kill_q == '0) & ~bus.jump_en_i;
    pc_d = bus.jump_en_i ? {bus.jump_addr_i[XLEN-1:2], 2'b00} : accept ? pc_q + 32'd4 : pc_q;
    out_d = out_q + OW'(accept) - OW'(bus.rsp_valid_i);
    kill_d = bus.jump_en_i ? out_q - OW'(bus.rsp_valid_i)
           : (bus.rsp_valid_i && kill_q != '0) ? kill_q - 1'b1 : kill_q;
    bus.inst_valid_o = ~buf_empty;
    bus.inst_o = buf_empty ? INST_NOP : head.inst;
    bus.inst_addr_o = buf_empty ? ZERO_WORD : head.addr;
  end
  // pc and in-flight counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      out_q <= '0;
      kill_q <= '0;
    end else begin
      pc_q <= pc_d;
      out_q <= out_d;
      kill_q <= kill_d;
    end
  end
  // in-flight tracking must match the address queue and never answer an absent request
  always_ff @(posedge clk) begin
    if (!rst) assert (aq_cnt == out_q && kill_q <= out_q && !(bus.rsp_valid_i && aq_empty) && !(accept && aq_full && !bus.rsp_valid_i));
  end
  ifu_fifo #(.W(XLEN), .D(MAX_OUTSTANDING)) u_addr_q (
    .clk(clk), .rst(rst), .flush_i(1'b0),
    .push_i(accept), .pop_i(bus.rsp_valid_i), .din_i(pc_q),
    .dout_o(aq_addr), .empty_o(aq_empty), .full_o(aq_full), .count_o(aq_cnt)
  );
  ifu_fifo #(.W($bits(fetch_t)), .D(BUF_DEPTH)) u_rsp_buf (
    .clk(clk), .rst(rst), .flush_i(bus.jump_en_i),
    .push_i(buf_push), .pop_i(bus.inst_ready_i), .din_i({aq_addr, bus.rsp_data_i}),
    .dout_o(head), .empty_o(buf_empty), .full_o(buf_full), .count_o(buf_cnt)
  );
  // a jump flushes the buffer, so a full buffer is only a concern when no flush happens
  always_ff @(posedge clk) begin
    if (!rst && !bus.jump_en_i) assert (!(buf_push && buf_full && !bus.inst_ready_i));
  end
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: randomized scoreboard bench with a program-order fetch model and in-order memory
module tb_ifu;
  import ifu_pkg::*;
  localparam logic [31:0] RPC = 32'hFFFF_FFF8;
  typedef struct {
    logic [31:0] a;
    int due;
  } pend_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int delivered = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  pend_t pend[$];
  ifu_if bus();
  ifu #(.RESET_PC(RPC), .MAX_OUTSTANDING(2), .BUF_DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic refill(input logic [31:0] s);
    exp_q.delete();
    for (int i = 0; i < 4096; i++) exp_q.push_back(s + 32'(4 * i));
  endtask
  always @(negedge clk) begin : mon
    logic [31:0] a;
    if (!rst && !bus.jump_en_i && bus.inst_valid_o && bus.inst_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL deliver: got %h but model has no expected entry", bus.inst_addr_o);
      end else begin
        a = exp_q.pop_front();
        chk("inst_addr", bus.inst_addr_o, a);
        chk("inst", bus.inst_o, memf(a));
        delivered++;
      end
    end
  end
  initial begin : stim
    logic [31:0] req_exp, tgt;
    logic rst_prev;
    int phase, lat, due;
    pend_t p;
    bus.req_ready_i = 1'b0;
    bus.rsp_valid_i = 1'b0;
    bus.rsp_data_i = '0;
    bus.jump_en_i = 1'b0;
    bus.jump_addr_i = '0;
    bus.inst_ready_i = 1'b0;
    refill(RPC);
    req_exp = RPC;
    @(negedge clk);
    chk("req_valid_in_reset", {31'b0, bus.req_valid_o}, 32'd0);
    @(posedge clk);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      cyc++;
      phase = (c / 400) % 3;
      rst_prev = rst;
      rst = phase != 0 && $urandom_range(0, 199) == 0;
      bus.jump_en_i = 1'b0;
      bus.rsp_valid_i = 1'b0;
      bus.rsp_data_i = $urandom;
      if (rst) begin
        pend.delete();
        refill(RPC);
        req_exp = RPC;
      end else begin
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          p = pend.pop_front();
          bus.rsp_valid_i = 1'b1;
          bus.rsp_data_i = memf(p.a);
        end
        if (phase != 0 && $urandom_range(0, 24) == 0) begin
          tgt = $urandom_range(0, 1) == 0 ? 32'h0000_0103 : $urandom;
          bus.jump_en_i = 1'b1;
          bus.jump_addr_i = tgt;
          refill({tgt[31:2], 2'b00});
          req_exp = {tgt[31:2], 2'b00};
        end else bus.jump_addr_i = $urandom;
      end
      bus.req_ready_i = phase == 0 ? 1'b1 : $urandom_range(0, 3) != 0;
      bus.inst_ready_i = phase == 0 ? 1'b1 : phase == 2 ? $urandom_range(0, 9) < 3 : $urandom_range(0, 3) != 0;
      @(negedge clk);
      if (rst) chk("req_valid_in_reset", {31'b0, bus.req_valid_o}, 32'd0);
      else if (bus.jump_en_i) chk("req_valid_in_jump", {31'b0, bus.req_valid_o}, 32'd0);
      if (rst_prev && !rst) begin
        chk("inst_valid_after_reset", {31'b0, bus.inst_valid_o}, 32'd0);
        chk("inst_after_reset", bus.inst_o, INST_NOP);
        chk("inst_addr_after_reset", bus.inst_addr_o, 32'd0);
      end
      if (!rst && bus.req_valid_o && bus.req_ready_i) begin
        chk("req_addr", bus.req_addr_o, req_exp);
        req_exp += 32'd4;
        lat = phase == 0 ? 1 : $urandom_range(1, 3);
        due = cyc + lat;
        if (pend.size() > 0 && due <= pend[$].due) due = pend[$].due + 1;
        p.a = bus.req_addr_o;
        p.due = due;
        pend.push_back(p);
        checks++;
        if (pend.size() > 2) begin
          failures++;
          $display("FAIL outstanding: got %0d requests in flight, limit 2", pend.size());
        end
      end
    end
    checks++;
    if (delivered < 200) begin
      failures++;
      $display("FAIL progress: got %0d deliveries, required at least 200", delivered);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
